// File: rtl/board_pkg.sv
// Shared Warships board definitions: cell encoding, default board geometry
// and an address range helper.
package board_pkg;

    localparam int unsigned BOARD_X_SIZE       = 16;
    localparam int unsigned BOARD_Y_SIZE       = 16;
    localparam int unsigned BOARD_X_ADDR_WIDTH = 4;
    localparam int unsigned BOARD_Y_ADDR_WIDTH = 4;
    localparam int unsigned BOARD_DATA_WIDTH   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    // True when column x and row y both fall inside the board.
    function automatic logic addr_in_range(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned x_size,
                                           input int unsigned y_size);
        return (x < x_size) && (y < y_size);
    endfunction

endpackage

// File: rtl/board_memory.sv
// Game-board storage: register array with one write port (game logic) and
// one registered read port (renderer) on a shared clock. Reset clears it all.
module board_memory
    import board_pkg::*;
#(
    parameter int unsigned X_SIZE       = BOARD_X_SIZE,
    parameter int unsigned Y_SIZE       = BOARD_Y_SIZE,
    parameter int unsigned X_ADDR_WIDTH = BOARD_X_ADDR_WIDTH,
    parameter int unsigned Y_ADDR_WIDTH = BOARD_Y_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = BOARD_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data,
    input  logic                                 write_enable,
    input  logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]                read_data
);

    localparam int unsigned CELLS = X_SIZE * Y_SIZE;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [DATA_WIDTH-1:0]   cells [CELLS];

    logic [X_ADDR_WIDTH-1:0] write_x, read_x;
    logic [Y_ADDR_WIDTH-1:0] write_y, read_y;
    logic                    write_valid, read_valid;
    logic [IDX_W-1:0]        write_index, read_index;

    assign {write_y, write_x} = write_addr;
    assign {read_y, read_x}   = read_addr;

    // Decode both {y, x} addresses into a linear cell index plus an in-range flag.
    always_comb begin
        write_valid = addr_in_range(32'(write_x), 32'(write_y), X_SIZE, Y_SIZE);
        read_valid  = addr_in_range(32'(read_x), 32'(read_y), X_SIZE, Y_SIZE);
        write_index = IDX_W'(32'(write_y) * X_SIZE + 32'(write_x));
        read_index  = IDX_W'(32'(read_y) * X_SIZE + 32'(read_x));
    end

    // Cell array: cleared on reset, otherwise one in-range cell written per strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CELLS; i++) begin
                cells[IDX_W'(i)] <= '0;
            end
        end else if (write_enable && write_valid) begin
            cells[write_index] <= write_data;
        end
    end

    // Registered read; samples the array before this edge's write, so a
    // same-cell read and write returns the old value. Out-of-range reads give 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (read_valid) begin
            read_data <= cells[read_index];
        end else begin
            read_data <= '0;
        end
    end

endmodule

// File: tb/tb_board_memory.sv
// Directed self-checking bench for board_memory: a default 16x16 instance
// and a 10x10 instance for out-of-range addressing.
module tb_board_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] write_addr, read_addr;
    logic [1:0] write_data, read_data;
    logic       write_enable;

    logic [7:0] s_write_addr, s_read_addr;
    logic [1:0] s_write_data, s_read_data;
    logic       s_write_enable;

    int checks = 0;
    int errors = 0;

    board_memory dut (
        .clk          (clk),
        .rst          (rst),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_addr    (read_addr),
        .read_data    (read_data)
    );

    board_memory #(
        .X_SIZE       (10),
        .Y_SIZE       (10),
        .X_ADDR_WIDTH (4),
        .Y_ADDR_WIDTH (4),
        .DATA_WIDTH   (2)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .write_addr   (s_write_addr),
        .write_data   (s_write_data),
        .write_enable (s_write_enable),
        .read_addr    (s_read_addr),
        .read_data    (s_read_data)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (read_data !== 2'd0) begin
            errors++;
            $display("FAIL reset_initial read_data=%0d expected=0", read_data);
        end
        // scatter some writes, then check an in-flight read is cleared by reset
        write_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_addr = 8'(i * 37 + 5);
            write_data = 2'(i | 1);
            tick();
        end
        write_addr   = 8'd5;
        write_data   = 2'd3;
        tick();
        write_enable = 1'b0;
        read_addr    = 8'd5;
        tick();
        checks++;
        if (read_data !== 2'd3) begin
            errors++;
            $display("FAIL reset_preread read_data=%0d expected=3", read_data);
        end
        // write during reset must be discarded
        rst          = 1'b1;
        write_enable = 1'b1;
        write_addr   = 8'd9;
        write_data   = 2'd2;
        tick();
        checks++;
        if (read_data !== 2'd0) begin
            errors++;
            $display("FAIL reset_inflight read_data=%0d expected=0", read_data);
        end
        tick();
        rst          = 1'b0;
        write_enable = 1'b0;
        for (int a = 0; a < 256; a++) begin
            read_addr = 8'(a);
            tick();
            checks++;
            if (read_data !== 2'd0) begin
                errors++;
                $display("FAIL reset_clear addr=%0d read_data=%0d expected=0", a, read_data);
            end
        end
    endtask

    task automatic test_seq_fill();
        write_enable = 1'b1;
        for (int a = 0; a < 256; a++) begin
            write_addr = 8'(a);
            write_data = 2'(a % 4);
            tick();
        end
        write_enable = 1'b0;
        for (int a = 0; a < 256; a++) begin
            read_addr = 8'(a);
            tick();
            checks++;
            if (read_data !== 2'(a % 4)) begin
                errors++;
                $display("FAIL seq_fill addr=%0d read_data=%0d expected=%0d", a, read_data, a % 4);
            end
        end
    endtask

    task automatic test_read_latency();
        write_enable = 1'b1;
        write_addr   = 8'h35;
        write_data   = 2'd2;
        tick();
        write_enable = 1'b0;
        read_addr    = 8'h00;
        tick();
        checks++;
        if (read_data !== 2'd0) begin
            errors++;
            $display("FAIL latency_pre read_data=%0d expected=0", read_data);
        end
        read_addr = 8'h35;
        #2;
        checks++;
        if (read_data !== 2'd0) begin
            errors++;
            $display("FAIL latency_early read_data=%0d expected=0", read_data);
        end
        tick();
        checks++;
        if (read_data !== 2'd2) begin
            errors++;
            $display("FAIL latency_k read_data=%0d expected=2", read_data);
        end
    endtask

    task automatic test_read_during_write();
        write_enable = 1'b1;
        write_addr   = 8'h10;
        write_data   = 2'd1;
        tick();
        write_data   = 2'd3;
        read_addr    = 8'h10;
        tick();
        write_enable = 1'b0;
        checks++;
        if (read_data !== 2'd1) begin
            errors++;
            $display("FAIL rdw_old read_data=%0d expected=1", read_data);
        end
        tick();
        checks++;
        if (read_data !== 2'd3) begin
            errors++;
            $display("FAIL rdw_new read_data=%0d expected=3", read_data);
        end
    endtask

    task automatic test_write_disabled();
        write_enable = 1'b0;
        write_addr   = 8'h22;
        write_data   = 2'd3;
        tick();
        tick();
        read_addr = 8'h22;
        tick();
        checks++;
        if (read_data !== 2'd2) begin
            errors++;
            $display("FAIL write_disabled read_data=%0d expected=2", read_data);
        end
    endtask

    task automatic test_back_to_back();
        write_enable = 1'b1;
        write_addr   = 8'hFF;
        write_data   = 2'd1;
        tick();
        write_addr   = 8'h00;
        write_data   = 2'd2;
        tick();
        write_enable = 1'b0;
        read_addr    = 8'hFF;
        tick();
        checks++;
        if (read_data !== 2'd1) begin
            errors++;
            $display("FAIL wrap_last read_data=%0d expected=1", read_data);
        end
        read_addr = 8'h00;
        tick();
        checks++;
        if (read_data !== 2'd2) begin
            errors++;
            $display("FAIL wrap_first read_data=%0d expected=2", read_data);
        end
    endtask

    task automatic test_out_of_range();
        s_write_enable = 1'b1;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                s_write_addr = {4'(y), 4'(x)};
                s_write_data = 2'd1;
                tick();
            end
        end
        // x=12,y=2 would alias cell 32 (y=3,x=2); y=12,x=2 would alias beyond
        s_write_data = 2'd3;
        s_write_addr = {4'd2, 4'd12};
        tick();
        s_write_addr = {4'd12, 4'd2};
        tick();
        s_write_enable = 1'b0;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                s_read_addr = {4'(y), 4'(x)};
                tick();
                checks++;
                if (s_read_data !== 2'd1) begin
                    errors++;
                    $display("FAIL oor_cell y=%0d x=%0d read_data=%0d expected=1", y, x, s_read_data);
                end
            end
        end
        s_read_addr = {4'd2, 4'd12};
        tick();
        checks++;
        if (s_read_data !== 2'd0) begin
            errors++;
            $display("FAIL oor_read_x read_data=%0d expected=0", s_read_data);
        end
        s_read_addr = {4'd12, 4'd2};
        tick();
        checks++;
        if (s_read_data !== 2'd0) begin
            errors++;
            $display("FAIL oor_read_y read_data=%0d expected=0", s_read_data);
        end
    endtask

    initial begin
        rst            = 1'b1;
        write_addr     = '0;
        write_data     = '0;
        write_enable   = 1'b0;
        read_addr      = '0;
        s_write_addr   = '0;
        s_write_data   = '0;
        s_write_enable = 1'b0;
        s_read_addr    = '0;
        test_reset();
        test_seq_fill();
        test_read_latency();
        test_read_during_write();
        test_write_disabled();
        test_back_to_back();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
